vga_frame_renderer: RTL

//  Parametrised successor to the fixed 400x300 renderer. Reads pixels from an external async SRAM frame store.

---
 rtl/vga_frame_renderer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/vga_frame_renderer.sv
// vga_frame_renderer
//   Turns sync-generator scan positions into SRAM read addresses for an
//   upscaled, multi-buffered frame store, and turns the returned pixel words
//   into 5-bit RGB for the DAC.
//
//   Ports
//     RENDERER_CLK / RENDERER_RST         pixel clock, synchronous active-high reset
//     RENDERER_POS_X/_POS_Y/_ENABLE       scan position and active-video flag
//     RENDERER_SEL_BUFF                   requested buffer, latched at (0,0)
//     RENDERER_BUF_ACTIVE                 buffer being scanned out
//     RENDERER_FRAME_START                1-cycle pulse after the (0,0) latch
//     RENDERER_DATA / RENDERER_ADDR       SRAM read data / address
//     RENDERER_WE/OE/CE                   SRAM strobes, tied 1/0/0
//     RENDERER_RED/GREEN/BLUE             colour to DAC
//     RENDERER_PAL_WE/_PAL_ADDR/_PAL_DATA palette write port (palette build only)
//
//   Build option: define VGA_FRAME_RENDERER_PALETTE_EN to add a 256x15
//   palette. With it, RGB332 pixels index the palette and total latency grows
//   by one cycle.
//
//   Addressing relies on the sync generator advancing POS by one step at a
//   time; counters resync to zero whenever POS_X or POS_Y returns to 0.
module vga_frame_renderer #(
    parameter int H_RES       = 400,
    parameter int V_RES       = 300,
    parameter int SCALE       = 2,
    parameter int NUM_BUFFERS = 2,
    parameter int COLOR_FMT   = 0,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 19,
    parameter int MEM_LAT     = 1
) (
    input  logic              RENDERER_CLK,
    input  logic              RENDERER_RST,
    input  logic [10:0]       RENDERER_POS_X,
    input  logic [9:0]        RENDERER_POS_Y,
    input  logic              RENDERER_ENABLE,
    input  logic [1:0]        RENDERER_SEL_BUFF,
    output logic [1:0]        RENDERER_BUF_ACTIVE,
    output logic              RENDERER_FRAME_START,
    input  logic [DATA_W-1:0] RENDERER_DATA,
    output logic [ADDR_W-1:0] RENDERER_ADDR,
    output logic              RENDERER_WE,
    output logic              RENDERER_OE,
    output logic              RENDERER_CE,
`ifdef VGA_FRAME_RENDERER_PALETTE_EN
    input  logic              RENDERER_PAL_WE,
    input  logic [7:0]        RENDERER_PAL_ADDR,
    input  logic [14:0]       RENDERER_PAL_DATA,
`endif
    output logic [4:0]        RENDERER_RED,
    output logic [4:0]        RENDERER_GREEN,
    output logic [4:0]        RENDERER_BLUE
);
    localparam int                BUF_SIZE  = H_RES * V_RES;
    localparam logic [10:0]       X_END     = 11'(H_RES * SCALE);
    localparam logic [9:0]        Y_END     = 10'(V_RES * SCALE);
    localparam logic [1:0]        SUB_MAX   = 2'(SCALE - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(H_RES);
    localparam logic [2:0]        NUM_BUF_L = 3'(NUM_BUFFERS);

    assign RENDERER_WE = 1'b1;
    assign RENDERER_OE = 1'b0;
    assign RENDERER_CE = 1'b0;

    logic [10:0]       prev_x;
    logic [9:0]        prev_y;
    logic [1:0]        x_sub, x_sub_c, y_sub, y_sub_c;
    logic [10:0]       x_log, x_log_c;
    logic [ADDR_W-1:0] row_base, row_base_c, buf_base_c;
    logic              frame_start_c, active_c;
    logic [1:0]        buf_next;
    logic [MEM_LAT:0]  act_pipe;

    // Column counters: x_log = POS_X / SCALE, x_sub = POS_X % SCALE.
    always_comb begin
        x_sub_c = x_sub;
        x_log_c = x_log;
        if (RENDERER_POS_X == 11'd0) begin
            x_sub_c = '0;
            x_log_c = '0;
        end else if (RENDERER_POS_X != prev_x) begin
            if (x_sub == SUB_MAX) begin
                x_sub_c = '0;
                x_log_c = x_log + 11'd1;
            end else begin
                x_sub_c = x_sub + 2'd1;
            end
        end
    end

    // Row counters: row_base = H_RES * (POS_Y / SCALE), stepped by addition.
    always_comb begin
        y_sub_c    = y_sub;
        row_base_c = row_base;
        if (RENDERER_POS_Y == 10'd0) begin
            y_sub_c    = '0;
            row_base_c = '0;
        end else if (RENDERER_POS_Y != prev_y) begin
            if (y_sub == SUB_MAX) begin
                y_sub_c    = '0;
                row_base_c = row_base + ROW_STEP;
            end else begin
                y_sub_c = y_sub + 2'd1;
            end
        end
    end

    assign frame_start_c = (RENDERER_POS_X == 11'd0) && (RENDERER_POS_Y == 10'd0);
    assign active_c      = RENDERER_ENABLE && (RENDERER_POS_X < X_END) && (RENDERER_POS_Y < Y_END);
    assign buf_next      = (frame_start_c && ({1'b0, RENDERER_SEL_BUFF} < NUM_BUF_L))
                           ? RENDERER_SEL_BUFF : RENDERER_BUF_ACTIVE;

    // Base from the buffer being latched, so pixel (0,0) already reads the new page.
    always_comb begin
        case (buf_next)
            2'd0:    buf_base_c = '0;
            2'd1:    buf_base_c = ADDR_W'(BUF_SIZE);
            2'd2:    buf_base_c = ADDR_W'(2 * BUF_SIZE);
            default: buf_base_c = ADDR_W'(3 * BUF_SIZE);
        endcase
    end

    always_ff @(posedge RENDERER_CLK) begin
        if (RENDERER_RST) begin
            prev_x               <= '0;
            prev_y               <= '0;
            x_sub                <= '0;
            x_log                <= '0;
            y_sub                <= '0;
            row_base             <= '0;
            RENDERER_BUF_ACTIVE  <= '0;
            RENDERER_FRAME_START <= 1'b0;
            RENDERER_ADDR        <= '0;
            act_pipe             <= '0;
        end else begin
            prev_x               <= RENDERER_POS_X;
            prev_y               <= RENDERER_POS_Y;
            x_sub                <= x_sub_c;
            x_log                <= x_log_c;
            y_sub                <= y_sub_c;
            row_base             <= row_base_c;
            RENDERER_BUF_ACTIVE  <= buf_next;
            RENDERER_FRAME_START <= frame_start_c;
            if (active_c) begin
                RENDERER_ADDR <= buf_base_c + row_base_c + ADDR_W'(x_log_c);
            end
            // act_pipe[MEM_LAT] lines up with DATA for the same pixel.
            act_pipe <= {act_pipe[MEM_LAT-1:0], active_c};
        end
    end

    logic [15:0] data_ext;
    logic        unused_bits;
    assign data_ext    = 16'(RENDERER_DATA);
    assign unused_bits = ^data_ext;

`ifdef VGA_FRAME_RENDERER_PALETTE_EN
    logic [14:0] pal_mem [0:255];
    logic [14:0] pix_q;
    logic        pix_act;

    // Registered read: a same-edge write to the same entry returns the old value.
    always_ff @(posedge RENDERER_CLK) begin
        if (RENDERER_PAL_WE) begin
            pal_mem[RENDERER_PAL_ADDR] <= RENDERER_PAL_DATA;
        end
    end

    always_ff @(posedge RENDERER_CLK) begin
        if (RENDERER_RST) begin
            pix_q          <= '0;
            pix_act        <= 1'b0;
            RENDERER_RED   <= '0;
            RENDERER_GREEN <= '0;
            RENDERER_BLUE  <= '0;
        end else begin
            pix_q   <= (COLOR_FMT == 0) ? pal_mem[data_ext[7:0]] : data_ext[14:0];
            pix_act <= act_pipe[MEM_LAT];
            RENDERER_RED   <= pix_act ? pix_q[4:0]   : 5'd0;
            RENDERER_GREEN <= pix_act ? pix_q[9:5]   : 5'd0;
            RENDERER_BLUE  <= pix_act ? pix_q[14:10] : 5'd0;
        end
    end
`else
    logic [4:0] dec_r, dec_g, dec_b;

    // 332 expansion replicates MSBs so full-scale codes map to 31.
    always_comb begin
        if (COLOR_FMT == 0) begin
            dec_r = {data_ext[2:0], data_ext[2:1]};
            dec_g = {data_ext[5:3], data_ext[5:4]};
            dec_b = {data_ext[7:6], data_ext[7:6], data_ext[7]};
        end else begin
            dec_r = data_ext[4:0];
            dec_g = data_ext[9:5];
            dec_b = data_ext[14:10];
        end
    end

    always_ff @(posedge RENDERER_CLK) begin
        if (RENDERER_RST) begin
            RENDERER_RED   <= '0;
            RENDERER_GREEN <= '0;
            RENDERER_BLUE  <= '0;
        end else begin
            RENDERER_RED   <= act_pipe[MEM_LAT] ? dec_r : 5'd0;
            RENDERER_GREEN <= act_pipe[MEM_LAT] ? dec_g : 5'd0;
            RENDERER_BLUE  <= act_pipe[MEM_LAT] ? dec_b : 5'd0;
        end
    end
`endif

endmodule
